// File: rtl/unidad_busqueda_pkg.sv
// Shared types and constants for the instruction fetch/sequencing unit.
// Holds the FSM encoding, default opcodes, the halt word and address width.
package unidad_busqueda_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [5:0]        OP_BEQ_DEF    = 6'b000100;
    localparam logic [5:0]        OP_J_DEF      = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } estado_t;

endpackage

// File: rtl/unidad_busqueda_memoria_ins.sv
// 32 x 32 instruction store: one write port, synchronous read with 1-cycle latency.
// Contents are deliberately not reset so a program survives a sequencer reset.
module memoria_ins
    import unidad_busqueda_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [NUM_WORDS];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction sequencer: fetches from the local store, issues over a valid/ready
// handshake, resolves BEQ/J targets on acceptance and stops on the halt word.
module unidad_busqueda
    import unidad_busqueda_pkg::*;
#(
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF,
    parameter logic [5:0]        OP_BEQ    = OP_BEQ_DEF,
    parameter logic [5:0]        OP_J      = OP_J_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] instruccion,
    input  logic              zf_in,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halt_o
);

    estado_t           state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instruccion_q, instruccion_d;
    logic              ins_valid_q, ins_valid_d;
    logic              halt_q, halt_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd_data;
    logic [5:0]        opcode;

    // The store is addressed with the next PC so the word is ready during FETCH.
    memoria_ins u_memoria_ins (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_d),
        .rd_data (mem_rd_data)
    );

    assign opcode = instruccion_q[DATA_W-1:DATA_W-6];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruccion_d = instruccion_q;
        ins_valid_d   = ins_valid_q;
        halt_d        = halt_q;
        mem_we        = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                mem_we = prog_we && !rst;
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    halt_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (mem_rd_data == HALT_WORD) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d       = ST_ISSUE;
                    instruccion_d = mem_rd_data;
                    ins_valid_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (ins_valid_q && ins_ready) begin
                    state_d     = ST_FETCH;
                    ins_valid_d = 1'b0;
                    if (opcode == OP_BEQ && zf_in) begin
                        pc_d = pc_q + ADDR_W'(1) + instruccion_q[ADDR_W-1:0];
                    end else if (opcode == OP_J) begin
                        pc_d = instruccion_q[ADDR_W-1:0];
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            instruccion_q <= '0;
            ins_valid_q   <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruccion_q <= instruccion_d;
            ins_valid_q   <= ins_valid_d;
            halt_q        <= halt_d;
        end
    end

    assign ins_valid   = ins_valid_q;
    assign instruccion = instruccion_q;
    assign pc_o        = pc_q;
    assign halt_o      = halt_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda: sequencing, stalls, branches, wrap, reset.
module tb_unidad_busqueda;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [31:0] prog_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] instruccion;
    logic        zf_in;
    logic [4:0]  pc_o;
    logic        halt_o;

    int total = 0;
    int fails = 0;

    unidad_busqueda dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .instruccion (instruccion),
        .zf_in       (zf_in),
        .pc_o        (pc_o),
        .halt_o      (halt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [4:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        ins_ready = 1'b0; zf_in = 1'b0;
        #2;
        do_reset();
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_instr", instruccion, 32'h0);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);

        // Straight-line program ending in the halt word
        prog(5'd0, 32'h0000_0020);
        prog(5'd1, 32'h0000_0022);
        prog(5'd2, 32'hFFFF_FFFF);
        ins_ready = 1'b1;
        pulse_start();
        chk("seq_fetch0_valid", 32'(ins_valid), 32'd0);
        tick();
        chk("seq_issue0_valid", 32'(ins_valid), 32'd1);
        chk("seq_issue0_instr", instruccion, 32'h0000_0020);
        chk("seq_issue0_pc", 32'(pc_o), 32'd0);
        tick();
        chk("seq_fetch1_valid", 32'(ins_valid), 32'd0);
        chk("seq_fetch1_pc", 32'(pc_o), 32'd1);
        tick();
        chk("seq_issue1_valid", 32'(ins_valid), 32'd1);
        chk("seq_issue1_instr", instruccion, 32'h0000_0022);
        tick();
        chk("seq_fetch2_pc", 32'(pc_o), 32'd2);
        tick();
        chk("seq_halt", 32'(halt_o), 32'd1);
        chk("seq_halt_pc", 32'(pc_o), 32'd2);
        chk("seq_halt_valid", 32'(ins_valid), 32'd0);
        tick();
        chk("seq_halt_hold", 32'(halt_o), 32'd1);

        // BEQ imm=3 with a stalled datapath; zf toggles while stalled must not matter
        prog(5'd0, 32'h1000_0003);
        prog(5'd1, 32'h0000_0011);
        prog(5'd4, 32'h0000_0044);
        prog(5'd5, 32'h0000_0055);
        ins_ready = 1'b0;
        pulse_start();
        chk("beq_restart_halt", 32'(halt_o), 32'd0);
        chk("beq_restart_pc", 32'(pc_o), 32'd0);
        tick();
        chk("beq_issue_instr", instruccion, 32'h1000_0003);
        for (int i = 0; i < 5; i++) begin
            zf_in = 1'(i);
            tick();
            chk("stall_valid", 32'(ins_valid), 32'd1);
            chk("stall_instr", instruccion, 32'h1000_0003);
            chk("stall_pc", 32'(pc_o), 32'd0);
        end
        ins_ready = 1'b1;
        zf_in = 1'b1;
        tick();
        zf_in = 1'b0;
        ins_ready = 1'b0;
        chk("beq_taken_pc", 32'(pc_o), 32'd4);
        chk("release_single_issue", 32'(ins_valid), 32'd0);
        tick();
        chk("beq_taken_instr", instruccion, 32'h0000_0044);
        chk("beq_taken_valid", 32'(ins_valid), 32'd1);

        // Reset mid-ISSUE overrides a same-cycle handshake
        rst = 1'b1;
        ins_ready = 1'b1;
        tick();
        rst = 1'b0;
        ins_ready = 1'b0;
        chk("rst_issue_valid", 32'(ins_valid), 32'd0);
        chk("rst_issue_pc", 32'(pc_o), 32'd0);
        chk("rst_issue_instr", instruccion, 32'h0);
        tick();
        chk("rst_issue_idle", 32'(ins_valid), 32'd0);

        // Same BEQ not taken; store must have survived the reset
        pulse_start();
        tick();
        chk("store_kept_w0", instruccion, 32'h1000_0003);
        ins_ready = 1'b1;
        zf_in = 1'b0;
        tick();
        ins_ready = 1'b0;
        chk("beq_not_taken_pc", 32'(pc_o), 32'd1);
        tick();
        chk("beq_not_taken_instr", instruccion, 32'h0000_0011);

        // Write attempt while issuing must be dropped
        prog(5'd5, 32'hDEAD_BEEF);
        chk("we_issue_hold", instruccion, 32'h0000_0011);

        // J to 31, then sequential wrap to 0
        do_reset();
        prog(5'd0, 32'h0800_001F);
        prog(5'd31, 32'h0000_0031);
        ins_ready = 1'b1;
        pulse_start();
        tick();
        chk("j_issue_instr", instruccion, 32'h0800_001F);
        tick();
        chk("j_target_pc", 32'(pc_o), 32'd31);
        tick();
        chk("j_target_instr", instruccion, 32'h0000_0031);
        tick();
        chk("wrap_pc", 32'(pc_o), 32'd0);
        tick();
        chk("wrap_instr", instruccion, 32'h0800_001F);

        // Read back word 5 through a jump
        do_reset();
        prog(5'd0, 32'h0800_0005);
        pulse_start();
        tick();
        tick();
        chk("w5_pc", 32'(pc_o), 32'd5);
        tick();
        chk("w5_unchanged", instruccion, 32'h0000_0055);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/unidad_busqueda.md
UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 Parameter: HALT_WORD, default 32'hFFFF_FFFF, instruction word that stops sequencing.
REQ-002 Parameter: OP_BEQ, default 6'b000100, opcode of conditional branch on zero flag.
REQ-003 Parameter: OP_J, default 6'b000010, opcode of absolute jump.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  pulse; begins sequencing from PC 0 when in IDLE or HALT.
REQ-007 prog_we  in  1  program-load write strobe.
REQ-008 prog_addr  in  5  program-load word index.
REQ-009 prog_data  in  32  program-load instruction word.
REQ-010 ins_valid  out  1  instruccion holds a valid word for the executing datapath.
REQ-011 ins_ready  in  1  datapath accepts instruccion this cycle.
REQ-012 instruccion  out  32  instruction issued to the datapath.
REQ-013 zf_in  in  1  zero flag returned by the datapath ALU, combinational with instruccion.
REQ-014 pc_o  out  5  word index of the currently issued or next fetched instruction.
REQ-015 halt_o  out  1  HALT_WORD reached; sequencing stopped.

Function
REQ-016 Instruction store: 32 x 32-bit words, synchronous read, 1-cycle latency, not cleared by reset.
REQ-017 prog_we writes prog_data to prog_addr only in IDLE or HALT; ignored in FETCH/ISSUE.
REQ-018 FSM states: IDLE, FETCH, ISSUE, HALT.
REQ-019 IDLE -> FETCH on start; PC <= 0, halt_o <= 0.
REQ-020 FETCH: store read at PC; next cycle -> ISSUE with instruccion loaded and ins_valid=1.
REQ-021 ISSUE: instruccion and ins_valid held stable until ins_valid && ins_ready (handshake).
REQ-022 On handshake, next PC: OP_BEQ with zf_in=1 -> PC+1+instruccion[4:0]; OP_J -> instruccion[4:0]; otherwise PC+1; then -> FETCH, ins_valid <= 0.
REQ-023 zf_in is sampled only in the handshake cycle; zf_in at any other time is ignored.
REQ-024 All PC arithmetic is 5-bit modulo 32: PC 31 + 1 -> 0; branch offsets wrap.
REQ-025 If the fetched word equals HALT_WORD: no issue, ins_valid stays 0; -> HALT, halt_o=1, pc_o holds the halt address.
REQ-026 HALT -> FETCH with PC <= 0 and halt_o <= 0 on start; otherwise HALT is held.
REQ-027 start is ignored in FETCH and ISSUE.
REQ-028 Minimum issue rate: one instruction per 2 cycles with ins_ready held high.

Reset
REQ-029 On rst: state=IDLE, PC=0, pc_o=0, ins_valid=0, instruccion=32'h0, halt_o=0.
REQ-030 rst has priority over start, prog_we and handshake in the same cycle.
REQ-031 rst mid-ISSUE drops ins_valid the following cycle without completing the handshake; store contents are preserved.

Structure
REQ-032 A shared package holds the FSM state enumeration, the OP_BEQ/OP_J opcode constants, HALT_WORD and the 5-bit address width.
REQ-033 One sub-module, memoria_ins, holds the 32 x 32 synchronous-read store with its write port; the FSM and PC logic stay in unidad_busqueda.

Verification
REQ-034 Load words 0..2 = 32'h0000_0020, 32'h0000_0022, HALT_WORD; start; ins_ready=1 -> issues at cycles 2 and 4; halt_o=1; pc_o=2.
REQ-035 Hold ins_ready=0 for 5 cycles in ISSUE -> instruccion and ins_valid stable; single issue on release.
REQ-036 Word 0 = BEQ with imm=3; zf_in=1 -> next pc_o=4. Repeat with zf_in=0 -> pc_o=1.
REQ-037 Word 31 = non-branch; jump to 31 via OP_J imm 31 -> next fetch at PC 0 (wrap).
REQ-038 Assert rst during ISSUE -> ins_valid=0 and state IDLE next cycle; after start, store contents are unchanged.
REQ-039 prog_we during ISSUE -> target word unchanged on a later read.
